// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, strobe/address constants and watchdog sizing for the DMA master
package mem_bus_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP, S_FIN} state_t;
    localparam logic [3:0]  WSTRB_NONE = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] ADDR_INC   = 32'd4;
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/mem_bus_watchdog.sv
// mem_bus_watchdog: counts stalled bus cycles and flags expiry after TIMEOUT of them
// Ports: clk/reset (async, active-high); clear restarts the count; wait_en counts a stalled cycle;
// expired is high once TIMEOUT stalled cycles have accumulated since the last clear.
module mem_bus_watchdog
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);
    localparam int W = wd_width(TIMEOUT);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (wait_en && !expired)
            r_cnt <= r_cnt + W'(1);
    assign expired = r_cnt == W'(TIMEOUT);
endmodule

// File: rtl/mem_dma_master.sv
// mem_dma_master: word-block copy engine mastering the PicoRV32 native memory bus
// Ports: start/src_addr/dst_addr/len_words configure a copy; busy/done/error/words_done report it;
// mem_* is the native bus initiator side (mem_instr tied low, reads use wstrb 0, writes 4'hF).
module mem_dma_master
    import mem_bus_pkg::*;
#(
    parameter int LEN_W   = 13,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);
    state_t           r_state, w_next;
    logic [31:0]      r_src, r_dst;
    logic [LEN_W-1:0] r_remaining;
    logic             w_accept, w_wait, w_clear, w_expired;

    assign mem_instr = 1'b0;
    assign w_accept  = r_state == S_IDLE && start;
    assign w_wait    = (r_state == S_RD || r_state == S_WR) && !mem_ready;
    assign w_clear   = w_next != r_state;

    mem_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .wait_en (w_wait),
        .expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (start && len_words != '0) ? S_RD : S_IDLE;
            S_RD:     w_next = mem_ready ? S_RD_GAP : (w_expired ? S_FIN : S_RD);
            S_RD_GAP: w_next = S_WR;
            S_WR:     w_next = mem_ready ? S_WR_GAP : (w_expired ? S_FIN : S_WR);
            S_WR_GAP: w_next = r_remaining == '0 ? S_FIN : S_RD;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;

    // Bus outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            words_done  <= '0;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= WSTRB_NONE;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
        end else begin
            mem_valid <= w_next == S_RD || w_next == S_WR;
            mem_wstrb <= w_next == S_WR ? WSTRB_WORD : WSTRB_NONE;
            busy      <= w_next != S_IDLE && w_next != S_FIN;
            done      <= w_next == S_FIN || (w_accept && len_words == '0);
            if (w_accept)
                error <= 1'b0;
            else if (w_wait && w_expired)
                error <= 1'b1;
            if (w_accept && len_words != '0) begin
                r_src       <= src_addr & ~32'd3;
                r_dst       <= dst_addr & ~32'd3;
                r_remaining <= len_words;
                words_done  <= '0;
                mem_addr    <= src_addr & ~32'd3;
            end
            // The read word lands directly in the write-data register; it is only driven onto a valid bus in WR.
            if (r_state == S_RD && mem_ready)
                mem_wdata <= mem_rdata;
            if (r_state == S_RD_GAP)
                mem_addr <= r_dst;
            if (r_state == S_WR_GAP)
                mem_addr <= r_src;
            if (r_state == S_WR && mem_ready) begin
                r_src       <= r_src + ADDR_INC;
                r_dst       <= r_dst + ADDR_INC;
                r_remaining <= r_remaining - LEN_W'(1);
                words_done  <= words_done + LEN_W'(1);
            end
        end
endmodule

// File: tb/tb_mem_dma_master.sv
// tb_mem_dma_master: randomized self-checking bench with a behavioural bus responder and copy model
module tb_mem_dma_master;
    localparam int LEN_W   = 13;
    localparam int TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy, done, error;
    logic [LEN_W-1:0] words_done;
    logic             mem_valid, mem_instr;
    logic [31:0]      mem_addr, mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_ready;
    logic [31:0]      mem_rdata;

    always #5 clk = ~clk;

    mem_dma_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] src_mem [bit [31:0]];
    logic [31:0] wr_mem  [bit [31:0]];
    int          mode = 0;
    int          hang_at = -1;
    int          rd_n = 0;
    logic [31:0] rd_log [0:1023];
    int          busy_cnt = 0, done_cnt = 0, valid_cnt = 0, stab_viol = 0, gap_viol = 0;

    // Responder: mode 0 = on-chip RAM (1 wait on reads, 0 on writes), 1 = random 0-5 waits, 2 = slow writes.
    initial begin : responder
        bit started;
        int waited, wt;
        mem_ready = 1'b0;
        mem_rdata = '0;
        started = 0;
        waited = 0;
        wt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_ready || !mem_valid) begin
                mem_ready = 1'b0;
                started = 0;
            end else begin
                if (!started) begin
                    started = 1;
                    waited = 0;
                    if (mem_wstrb == 4'h0) begin
                        rd_log[rd_n % 1024] = mem_addr;
                        wt = (rd_n == hang_at) ? (1 << 30) : (mode == 1 ? int'($urandom_range(0, 5)) : 1);
                        rd_n++;
                    end else
                        wt = mode == 1 ? int'($urandom_range(0, 5)) : (mode == 2 ? 3 : 0);
                end
                if (waited >= wt) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'h0)
                        mem_rdata = src_mem.exists(mem_addr) ? src_mem[mem_addr] : 32'hBAD0BAD0;
                    else
                        wr_mem[mem_addr] = mem_wdata;
                end else
                    waited++;
            end
        end
    end

    // Bus monitor: mem_ready seen at a negedge is the value the preceding posedge sampled.
    initial begin : monitor
        logic        p_valid;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_wstrb;
        p_valid = 1'b0;
        p_addr = '0;
        p_wdata = '0;
        p_wstrb = '0;
        forever begin
            @(negedge clk);
            if (p_valid && mem_ready && mem_valid)
                gap_viol++;
            if (p_valid && !mem_ready && mem_valid &&
                (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_wstrb !== p_wstrb))
                stab_viol++;
            busy_cnt  += int'(busy);
            done_cnt  += int'(done);
            valid_cnt += int'(mem_valid);
            p_valid = mem_valid;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_wstrb = mem_wstrb;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] wr_at(input logic [31:0] a);
        return wr_mem.exists(a) ? wr_mem[a] : 32'hxxxxxxxx;
    endfunction

    task automatic go(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len_words = LEN_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit got);
        got = 0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge clk);
            got = done;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, error, mem_valid, mem_instr} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, error, mem_valid, mem_instr}); end
        checks++; if (words_done !== '0) begin errors++; $display("FAIL reset_words_done: got %0d want 0", words_done); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_mem_wstrb: got %h want 0", mem_wstrb); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, mem_valid} !== 3'b0) begin errors++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, mem_valid}); end
    endtask

    task automatic test_ram_copy();
        bit got;
        int b0, d0, g0;
        mode = 0;
        for (int i = 0; i < 4; i++) src_mem[32'h1000 + 32'(4 * i)] = 32'hA5A50000 + 32'(i);
        b0 = busy_cnt; d0 = done_cnt; g0 = gap_viol;
        go(32'h1000, 32'h2000, 4);
        wait_done(500, got);
        checks++; if (!got) begin errors++; $display("FAIL ram_done_seen: got 0 want 1"); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (wr_at(32'h2000 + 32'(4 * i)) !== 32'hA5A50000 + 32'(i)) begin errors++; $display("FAIL ram_data[%0d]: got %h want %h", i, wr_at(32'h2000 + 32'(4 * i)), 32'hA5A50000 + 32'(i)); end
        end
        checks++; if (words_done !== LEN_W'(4)) begin errors++; $display("FAIL ram_words_done: got %0d want 4", words_done); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ram_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ram_error: got %b want 0", error); end
        checks++; if (busy_cnt - b0 != 20) begin errors++; $display("FAIL ram_busy_cycles: got %0d want 20", busy_cnt - b0); end
        checks++; if (gap_viol - g0 != 0) begin errors++; $display("FAIL ram_gap: got %0d back-to-back valids want 0", gap_viol - g0); end
    endtask

    task automatic test_random_wait();
        bit got;
        int s0, g0;
        logic [31:0] exp [16];
        mode = 1;
        for (int i = 0; i < 16; i++) begin
            exp[i] = $urandom;
            src_mem[32'h4000 + 32'(4 * i)] = exp[i];
        end
        s0 = stab_viol; g0 = gap_viol;
        go(32'h4000, 32'h8000, 16);
        wait_done(16 * 30 + 50, got);
        checks++; if (!got) begin errors++; $display("FAIL rnd_done_seen: got 0 want 1"); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            checks++; if (wr_at(32'h8000 + 32'(4 * i)) !== exp[i]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, wr_at(32'h8000 + 32'(4 * i)), exp[i]); end
        end
        checks++; if (words_done !== LEN_W'(16)) begin errors++; $display("FAIL rnd_words_done: got %0d want 16", words_done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rnd_error: got %b want 0", error); end
        checks++; if (stab_viol - s0 != 0) begin errors++; $display("FAIL rnd_stable: got %0d unstable cycles want 0", stab_viol - s0); end
        checks++; if (gap_viol - g0 != 0) begin errors++; $display("FAIL rnd_gap: got %0d back-to-back valids want 0", gap_viol - g0); end
    endtask

    task automatic test_timeout();
        bit got;
        int v0, d0;
        mode = 0;
        for (int i = 0; i < 5; i++) src_mem[32'h3000 + 32'(4 * i)] = 32'h5A000000 + 32'(i);
        hang_at = rd_n + 2;
        v0 = valid_cnt; d0 = done_cnt;
        go(32'h3000, 32'h3800, 5);
        wait_done(TIMEOUT * 2 + 200, got);
        checks++; if (!got) begin errors++; $display("FAIL to_done_seen: got 0 want 1"); end
        repeat (3) @(negedge clk);
        hang_at = -1;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error: got %b want 1", error); end
        checks++; if (words_done !== LEN_W'(2)) begin errors++; $display("FAIL to_words_done: got %0d want 2", words_done); end
        checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL to_idle: got valid/busy %b want 00", {mem_valid, busy}); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL to_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (valid_cnt - v0 < 6 + TIMEOUT || valid_cnt - v0 > 7 + TIMEOUT) begin errors++; $display("FAIL to_valid_cycles: got %0d want %0d..%0d", valid_cnt - v0, 6 + TIMEOUT, 7 + TIMEOUT); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (wr_at(32'h3800 + 32'(4 * i)) !== 32'h5A000000 + 32'(i)) begin errors++; $display("FAIL to_data[%0d]: got %h want %h", i, wr_at(32'h3800 + 32'(4 * i)), 32'h5A000000 + 32'(i)); end
        end
    endtask

    task automatic test_zero_len();
        int v0, b0;
        v0 = valid_cnt; b0 = busy_cnt;
        go(32'h1000, 32'h2000, 0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL zero_error_cleared: got %b want 0", error); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_single: got %b want 0", done); end
        repeat (4) @(negedge clk);
        checks++; if (valid_cnt - v0 != 0) begin errors++; $display("FAIL zero_no_bus: got %0d valid cycles want 0", valid_cnt - v0); end
        checks++; if (busy_cnt - b0 != 0) begin errors++; $display("FAIL zero_no_busy: got %0d busy cycles want 0", busy_cnt - b0); end
    endtask

    task automatic test_reset_mid();
        bit got, found;
        logic [31:0] exp [3];
        mode = 2;
        for (int i = 0; i < 4; i++) src_mem[32'h9000 + 32'(4 * i)] = $urandom;
        go(32'h9000, 32'hA000, 4);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            found = mem_valid && mem_wstrb == 4'hF;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_write_seen: got 0 want 1"); end
        #3 reset = 1'b1;
        #1;
        checks++; if ({mem_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_async_drop: got valid/busy %b want 00", {mem_valid, busy}); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mode = 0;
        for (int i = 0; i < 3; i++) begin
            exp[i] = $urandom;
            src_mem[32'hB000 + 32'(4 * i)] = exp[i];
        end
        go(32'hB000, 32'hC000, 3);
        wait_done(200, got);
        checks++; if (!got) begin errors++; $display("FAIL rst_done_seen: got 0 want 1"); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (wr_at(32'hC000 + 32'(4 * i)) !== exp[i]) begin errors++; $display("FAIL rst_data[%0d]: got %h want %h", i, wr_at(32'hC000 + 32'(4 * i)), exp[i]); end
        end
        checks++; if (words_done !== LEN_W'(3)) begin errors++; $display("FAIL rst_words_done: got %0d want 3", words_done); end
    endtask

    task automatic test_wrap_busy_start();
        bit got;
        int n0, b0, d0;
        logic [31:0] base, a;
        logic [31:0] exp [3];
        mode = 0;
        base = 32'hFFFFFFF8;
        for (int i = 0; i < 3; i++) begin
            exp[i] = $urandom;
            src_mem[base + 32'(4 * i)] = exp[i];
        end
        n0 = rd_n; b0 = busy_cnt; d0 = done_cnt;
        go(base, 32'hD000, 3);
        repeat (4) @(negedge clk);
        src_addr = 32'h5000; len_words = LEN_W'(7); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, got);
        checks++; if (!got) begin errors++; $display("FAIL wrap_done_seen: got 0 want 1"); end
        repeat (4) @(negedge clk);
        checks++; if (rd_n - n0 != 3) begin errors++; $display("FAIL wrap_read_count: got %0d want 3", rd_n - n0); end
        for (int i = 0; i < 3; i++) begin
            a = base + 32'(4 * i);
            checks++; if (rd_log[(n0 + i) % 1024] !== a) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %h want %h", i, rd_log[(n0 + i) % 1024], a); end
            checks++; if (wr_at(32'hD000 + 32'(4 * i)) !== exp[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, wr_at(32'hD000 + 32'(4 * i)), exp[i]); end
        end
        checks++; if (busy_cnt - b0 != 15) begin errors++; $display("FAIL wrap_busy_cycles: got %0d want 15", busy_cnt - b0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wrap_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (words_done !== LEN_W'(3)) begin errors++; $display("FAIL wrap_words_done: got %0d want 3", words_done); end
    endtask

    initial begin
        test_reset();
        test_ram_copy();
        test_random_wait();
        test_timeout();
        test_zero_len();
        test_reset_mid();
        test_wrap_busy_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
